// File: rtl/servo_pkg.sv
// Shared definitions for the servo PWM bank: command field layout, status error code and FSM states.
package servo_pkg;
  localparam int CH_MSB  = 15;
  localparam int CH_LSB  = 12;
  localparam int VAL_MSB = 11;
  localparam int VAL_LSB = 0;

  localparam logic [15:0] STATUS_ERR = 16'hFFFF;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

  function automatic logic [11:0] clamp12(input logic [11:0] v,
                                          input logic [11:0] lo,
                                          input logic [11:0] hi);
    if (v < lo)      clamp12 = lo;
    else if (v > hi) clamp12 = hi;
    else             clamp12 = v;
  endfunction
endpackage

// File: rtl/servo_pwm_channel.sv
// One servo output: shadow/active setpoint pair and registered pwm comparator.
// With SERVO_SLEW_EN defined, active walks toward shadow by at most SLEW_STEP per frame.
module servo_pwm_channel
  import servo_pkg::*;
#(
  parameter int TW            = 15,
  parameter int PULSE_DEFAULT = 1500,
  parameter int SLEW_STEP     = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [TW-1:0] i_tick,
  input  logic          i_frame,
  input  logic          i_wr_en,
  input  logic [11:0]   i_wr_data,
  output logic          o_pwm
);
  logic [11:0] r_shadow;
  logic [11:0] r_active;
  logic        r_pwm;
  logic [11:0] w_active_nxt;

`ifdef SERVO_SLEW_EN
  logic [11:0] w_diff;
  logic [11:0] w_step;
  always_comb begin
    w_diff       = (r_shadow > r_active) ? (r_shadow - r_active) : (r_active - r_shadow);
    w_step       = (w_diff > 12'(SLEW_STEP)) ? 12'(SLEW_STEP) : w_diff;
    w_active_nxt = (r_shadow > r_active) ? (r_active + w_step) : (r_active - w_step);
  end
`else
  assign w_active_nxt = r_shadow;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shadow <= 12'(PULSE_DEFAULT);
      r_active <= 12'(PULSE_DEFAULT);
      r_pwm    <= 1'b0;
    end else begin
      // Boundary reads the pre-write shadow; a same-cycle write lands next frame.
      if (i_wr_en) r_shadow <= i_wr_data;
      if (i_frame) r_active <= w_active_nxt;
      r_pwm <= (32'(i_tick) < 32'(r_active));
    end
  end

  assign o_pwm = r_pwm;
endmodule

// File: rtl/servo_pwm_bank.sv
// Multi-channel servo pulse generator: shared tick/frame timebase, stb/ack command FSM and
// CHANNELS double-buffered outputs. Optional slew limiting with SERVO_SLEW_EN.
module servo_pwm_bank
  import servo_pkg::*;
#(
  parameter int CHANNELS      = 8,
  parameter int TICK_CYCLES   = 50,
  parameter int PERIOD_TICKS  = 20000,
  parameter int PULSE_MIN     = 1000,
  parameter int PULSE_MAX     = 2000,
  parameter int PULSE_DEFAULT = 1500,
  parameter int SLEW_STEP     = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         input_control,
  input  logic                input_control_stb,
  output logic                input_control_ack,
  output logic [15:0]         output_status,
  output logic                output_status_stb,
  input  logic                output_status_ack,
  output logic [CHANNELS-1:0] pwm
);
  localparam int PW = (TICK_CYCLES  > 1) ? $clog2(TICK_CYCLES)  : 1;
  localparam int TW = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;

  logic [PW-1:0] r_pre;
  logic [TW-1:0] r_tick;
  logic          w_pre_wrap;
  logic          w_frame;

  assign w_pre_wrap = (r_pre == PW'(TICK_CYCLES - 1));
  assign w_frame    = w_pre_wrap && (r_tick == TW'(PERIOD_TICKS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre  <= '0;
      r_tick <= '0;
    end else if (w_pre_wrap) begin
      r_pre  <= '0;
      r_tick <= w_frame ? '0 : r_tick + 1'b1;
    end else begin
      r_pre  <= r_pre + 1'b1;
    end
  end

  state_t      r_state, w_state_nxt;
  logic        w_accept, w_exec;
  logic        r_ack;
  logic [15:0] r_cmd;
  logic [15:0] r_status;
  logic [3:0]  w_ch;
  logic        w_ch_ok;
  logic [11:0] w_val;
  logic [15:0] w_status;

  assign w_ch     = r_cmd[CH_MSB:CH_LSB];
  assign w_ch_ok  = (5'(w_ch) < 5'(CHANNELS));
  assign w_val    = clamp12(r_cmd[VAL_MSB:VAL_LSB], 12'(PULSE_MIN), 12'(PULSE_MAX));
  assign w_status = w_ch_ok ? {w_ch, w_val} : STATUS_ERR;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_ack    <= 1'b0;
      r_cmd    <= '0;
      r_status <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_accept;
      if (w_accept) r_cmd    <= input_control;
      if (w_exec)   r_status <= w_status;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_exec      = 1'b0;
    case (r_state)
      ST_IDLE: if (input_control_stb) begin
        w_accept    = 1'b1;
        w_state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        w_exec      = 1'b1;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: if (output_status_ack) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign input_control_ack = r_ack;
  assign output_status     = r_status;
  assign output_status_stb = (r_state == ST_RESP);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    servo_pwm_channel #(
      .TW(TW), .PULSE_DEFAULT(PULSE_DEFAULT), .SLEW_STEP(SLEW_STEP)
    ) u_ch (
      .clk(clk), .rst(rst),
      .i_tick(r_tick), .i_frame(w_frame),
      .i_wr_en(w_exec && w_ch_ok && (w_ch == 4'(g))),
      .i_wr_data(w_val),
      .o_pwm(pwm[g])
    );
  end
endmodule
